// File: rtl/binop_sched.sv
// binop_sched: two-requester arithmetic scheduler with a single shared
// ADD/SUB/MUL/DIV unit. One operation is in flight at a time. DIV uses a
// restoring divider that retires one quotient bit per cycle.
//
// Optional feature macro: BINOP_SCHED_REM_EN
//   defined   -> RES_REM carries the DIV remainder (0 for ADD/SUB/MUL,
//                zero-extended A for DIV by zero)
//   undefined -> RES_REM is constant 0 and no remainder output register exists
//
// Handshake: a request transfers on a rising edge where REQn_VALID and
// REQn_READY are both high; a result transfers on a rising edge where
// RES_VALID and RES_READY are both high. VALID never depends on READY of
// the same channel, and once RES_VALID is high the result fields stay
// stable until the transfer.
//
// DBG_STATE exposes the FSM state (0=IDLE, 1=DIV, 2=DONE).
module binop_sched #(
    parameter int NA = 8,
    parameter int NB = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0_VALID,
    input  logic          REQ1_VALID,
    output logic          REQ0_READY,
    output logic          REQ1_READY,
    input  logic [1:0]    REQ0_OP,
    input  logic [1:0]    REQ1_OP,
    input  logic [NA-1:0] REQ0_A,
    input  logic [NA-1:0] REQ1_A,
    input  logic [NB-1:0] REQ0_B,
    input  logic [NB-1:0] REQ1_B,
    output logic          RES_VALID,
    input  logic          RES_READY,
    output logic [NB-1:0] RES_DATA,
    output logic          RES_ID,
    output logic          RES_DIVZ,
    output logic [NB-1:0] RES_REM,
    output logic [1:0]    DBG_STATE
);

    localparam int CW = $clog2(NB + 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // Requester granted most recently; reset to 1 so requester 0 wins first
    logic          last_grant;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          sel;

    logic [1:0]    sel_op;
    logic [NB-1:0] sel_a_ext;
    logic [NB-1:0] sel_b;
    logic          sel_is_div;
    logic          sel_bzero;
    logic [NB-1:0] alu_res;

    // Divider working registers
    logic [NB-1:0] quot;
    logic [NB-1:0] part;
    logic [NB-1:0] divisor;
    logic [CW-1:0] cnt;
    logic          div_last;

    logic [NB:0]   shifted;
    logic [NB-1:0] diff;
    logic          ge;
    logic [NB-1:0] part_nxt;
    logic [NB-1:0] quot_nxt;

    // Result registers
    logic [NB-1:0] res_data_q;
    logic          res_id_q;
    logic          res_divz_q;
`ifdef BINOP_SCHED_REM_EN
    logic [NB-1:0] res_rem_q;
`endif

    // Round-robin arbitration: a lone requester wins; on contention the
    // requester that was not granted last wins.
    always_comb begin
        grant0 = REQ0_VALID && (!REQ1_VALID || last_grant);
        grant1 = REQ1_VALID && (!REQ0_VALID || !last_grant);
    end

    // Operand selection from the granted requester
    always_comb begin
        sel        = REQ1_READY;
        accept     = REQ0_READY || REQ1_READY;
        sel_op     = sel ? REQ1_OP : REQ0_OP;
        sel_a_ext  = sel ? NB'(REQ1_A) : NB'(REQ0_A);
        sel_b      = sel ? REQ1_B : REQ0_B;
        sel_is_div = (sel_op == OP_DIV);
        sel_bzero  = (sel_b == '0);
    end

    // Single-cycle ALU; the DIV slot yields the divide-by-zero quotient
    always_comb begin
        alu_res = '0;
        case (sel_op)
            OP_ADD:  alu_res = sel_a_ext + sel_b;
            OP_SUB:  alu_res = sel_a_ext - sel_b;
            OP_MUL:  alu_res = sel_a_ext * sel_b;
            default: alu_res = '1;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract
    // the divisor when it fits, and shift the outcome into the quotient.
    always_comb begin
        shifted  = {part, quot[NB-1]};
        ge       = (shifted >= {1'b0, divisor});
        diff     = shifted[NB-1:0] - divisor;
        part_nxt = ge ? diff : shifted[NB-1:0];
        quot_nxt = {quot[NB-2:0], ge};
        div_last = (cnt == CW'(NB - 1));
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (sel_is_div && !sel_bzero) ? S_DIV : S_DONE;
                end
            end
            S_DIV: begin
                if (div_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (RES_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: grants only in IDLE and never during reset
    always_comb begin
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        if ((state == S_IDLE) && !RST) begin
            REQ0_READY = grant0;
            REQ1_READY = grant1;
        end
        RES_VALID = (state == S_DONE);
        DBG_STATE = state;
    end

    // Datapath: capture on acceptance, iterate the divider, load results
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 1'b1;
            quot       <= '0;
            part       <= '0;
            divisor    <= '0;
            cnt        <= '0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_divz_q <= 1'b0;
`ifdef BINOP_SCHED_REM_EN
            res_rem_q  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        last_grant <= sel;
                        res_id_q   <= sel;
                        if (!sel_is_div) begin
                            res_data_q <= alu_res;
                            res_divz_q <= 1'b0;
`ifdef BINOP_SCHED_REM_EN
                            res_rem_q  <= '0;
`endif
                        end else if (sel_bzero) begin
                            res_data_q <= alu_res;
                            res_divz_q <= 1'b1;
`ifdef BINOP_SCHED_REM_EN
                            res_rem_q  <= sel_a_ext;
`endif
                        end else begin
                            quot       <= sel_a_ext;
                            part       <= '0;
                            divisor    <= sel_b;
                            cnt        <= '0;
                            res_divz_q <= 1'b0;
                        end
                    end
                end
                S_DIV: begin
                    quot <= quot_nxt;
                    part <= part_nxt;
                    cnt  <= cnt + CW'(1);
                    if (div_last) begin
                        res_data_q <= quot_nxt;
`ifdef BINOP_SCHED_REM_EN
                        res_rem_q  <= part_nxt;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result ports
    always_comb begin
        RES_DATA = res_data_q;
        RES_ID   = res_id_q;
        RES_DIVZ = res_divz_q;
`ifdef BINOP_SCHED_REM_EN
        RES_REM  = res_rem_q;
`else
        RES_REM  = '0;
`endif
    end

endmodule

// File: doc/binop_sched.md
BINOP_SCHED -- requirements
Module: binop_sched

Interface
REQ-001 SHALL have parameter NA, default 8, meaning operand A width in bits.
REQ-002 SHALL have parameter NB, default 16, meaning operand B, result and remainder width in bits (NB >= NA).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports REQ0_VALID/REQ1_VALID  input  1 each  requester n has an operation pending.
REQ-006 SHALL have ports REQ0_READY/REQ1_READY  output  1 each  requester n's operation is accepted this cycle.
REQ-007 SHALL have ports REQ0_OP/REQ1_OP  input  2 each  opcode: 0=ADD, 1=SUB, 2=MUL, 3=DIV.
REQ-008 SHALL have ports REQ0_A/REQ1_A  input  NA each  operand A, unsigned.
REQ-009 SHALL have ports REQ0_B/REQ1_B  input  NB each  operand B, unsigned.
REQ-010 SHALL have port RES_VALID  output  1  result is available.
REQ-011 SHALL have port RES_READY  input  1  consumer takes the result.
REQ-012 SHALL have port RES_DATA  output  NB  result value.
REQ-013 SHALL have port RES_ID  output  1  index of the requester that issued the result.
REQ-014 SHALL have port RES_DIVZ  output  1  the DIV had B == 0.
REQ-015 SHALL have port RES_REM  output  NB  DIV remainder (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, DIV, DONE, with exactly one operation in flight.
REQ-017 SHALL assert REQn_READY only in IDLE, only for the granted requester, and never for both in one cycle.
REQ-018 SHALL grant in IDLE with round-robin: only one valid -> that one; both valid -> the requester not granted last.
REQ-019 SHALL treat REQn_VALID && REQn_READY as acceptance, capturing OP, A (zero-extended to NB) and B, and latching RES_ID = n.
REQ-020 SHALL, on acceptance of ADD/SUB/MUL, go to DONE with RES_DATA = (A+B), (A-B) or (A*B) truncated modulo 2^NB, so RES_VALID rises the cycle after acceptance.
REQ-021 SHALL, on acceptance of DIV with B != 0, go to DIV and run a restoring divider, one quotient bit per cycle, for exactly NB cycles, then go to DONE; RES_VALID rises NB+1 cycles after acceptance.
REQ-022 SHALL, on acceptance of DIV with B == 0, go directly to DONE with RES_DATA = all ones, RES_REM = zero-extended A, and RES_DIVZ = 1.
REQ-023 SHALL set RES_DIVZ = 0 for every result other than DIV with B == 0.
REQ-024 SHALL, in DONE, hold RES_VALID, RES_DATA, RES_ID, RES_DIVZ and RES_REM stable until RES_READY is high, then return to IDLE on that edge.
REQ-025 SHALL NOT grant a new request in the cycle in which DONE is exited; the earliest next acceptance is the following cycle.
REQ-026 SHALL ignore REQn_* inputs while in DIV and DONE, and ignore RES_READY outside DONE.

Reset
REQ-027 SHALL, while RST is high, force state IDLE, RES_VALID = 0, RES_DATA = 0, RES_ID = 0, RES_DIVZ = 0, RES_REM = 0, REQ0_READY = REQ1_READY = 0, and the round-robin pointer so that requester 0 wins the first contention.
REQ-028 SHALL abort any in-flight operation on RST assertion (including mid-DIV or in DONE), with no result emitted after release.

Configuration
REQ-029 SHALL honour macro BINOP_SCHED_REM_EN: when defined, RES_REM carries the DIV remainder (A mod B) and equals 0 for ADD/SUB/MUL.
REQ-030 SHALL, without BINOP_SCHED_REM_EN, drive RES_REM constant 0 (including for DIV with B == 0) and omit remainder storage; the quotient path is unchanged.

Verification
REQ-031 SHALL cover: REQ0 ADD A=8'hFF B=16'h0001 -> RES_DATA=16'h0100, RES_ID=0, RES_VALID one cycle after acceptance.
REQ-032 SHALL cover: REQ1 SUB A=8'h05 B=16'h0007 -> RES_DATA=16'hFFFE; MUL A=8'hFF B=16'h0101 -> RES_DATA=16'hFFFF.
REQ-033 SHALL cover: DIV A=8'hC8 B=16'h0007 -> RES_DATA=16'h001C exactly 17 cycles after acceptance, with RES_REM=16'h0004 (REM_EN) or 0 (no macro).
REQ-034 SHALL cover: DIV B=0, A=8'h2A -> RES_DATA=16'hFFFF, RES_DIVZ=1 the cycle after acceptance, with RES_REM=16'h002A (REM_EN) or 0 (no macro).
REQ-035 SHALL cover: both requesters permanently valid -> grants alternate 0,1,0,1 after reset; with RES_READY held low for 5 cycles, outputs stay stable and no REQn_READY is asserted.
REQ-036 SHALL cover: RST pulsed at cycle 8 of a DIV -> all outputs return to reset values, RES_VALID never rises for that operation, and the next contention is granted to requester 0.
